// File: rtl/companion_state_update_pkg.sv
// companion_state_update_pkg: shared widths, FSM encoding, coefficients and saturation helper
package companion_state_update_pkg;
  localparam int W = 16;
  localparam int FRAC = 8;
  localparam int SW = 2 * W + 2;
  localparam logic signed [W-1:0] DEF_KL = 16'sh0080;
  localparam logic signed [W-1:0] DEF_KC = 16'sh0200;
  typedef enum logic [1:0] {IDLE, MUL_L, MUL_C, OUT} state_e;
  // Returns {clamped, value}; in range when every bit above the W-bit sign agrees with it.
  function automatic logic [W:0] sat_w(input logic signed [SW-1:0] x);
    logic ok;
    ok = (&x[SW-1:W-1]) | ~(|x[SW-1:W-1]);
    return ok ? {1'b0, x[W-1:0]} : {1'b1, x[SW-1], {(W-1){~x[SW-1]}}};
  endfunction
endpackage

// File: rtl/companion_mul.sv
// companion_mul: combinational signed (W+1)x(W) multiplier, swappable for a DSP wrapper
module companion_mul #(
  parameter int W = 16
) (
  input  logic signed [W:0]   a,
  input  logic signed [W-1:0] b,
  output logic signed [2*W:0] p
);
  assign p = (2*W+1)'(a) * (2*W+1)'(b);
endmodule

// File: rtl/companion_state_update.sv
// companion_state_update: updates inductor/capacitor history currents and emits the RHS vector z
module companion_state_update
  import companion_state_update_pkg::*;
#(
  parameter int FRAC_P = FRAC,
  parameter logic signed [W-1:0] KL = DEF_KL,
  parameter logic signed [W-1:0] KC = DEF_KC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] v1,
  input  logic signed [W-1:0] v2,
  input  logic signed [W-1:0] e_src,
  input  logic                hist_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        z0,
  output logic [W-1:0]        z1,
  output logic [W-1:0]        z2,
  output logic                sat
);
  state_e state_q, state_d;
  logic signed [W-1:0] v1_q, v1_d, v2_q, v2_d, e_q, e_d;
  logic signed [W-1:0] il_q, il_d, ic_q, ic_d;
  logic [W-1:0] z0_q, z0_d, z1_q, z1_d, z2_q, z2_d;
  logic sat_q, sat_d;
  logic signed [W:0] mul_a;
  logic signed [W-1:0] mul_b;
  logic signed [2*W:0] prod, t;
  logic [W:0] sl, sc, s0, s1;

  // One multiplier shared between the inductor and capacitor updates.
  assign mul_a = state_q == MUL_L ? (W+1)'(v1_q) - (W+1)'(v2_q) : (W+1)'(v2_q);
  assign mul_b = state_q == MUL_L ? KL : KC;

  companion_mul #(.W(W)) u_mul (.a(mul_a), .b(mul_b), .p(prod));

  assign t  = prod >>> FRAC_P;
  assign sl = sat_w(SW'(il_q) + SW'(t));
  assign sc = sat_w(SW'(t) - SW'(ic_q));
  assign s0 = sat_w(-SW'(il_q));
  // z1 must see the I_C value being written on the same edge.
  assign s1 = sat_w(SW'(il_q) + SW'($signed(sc[W-1:0])));

  always_comb begin
    state_d = state_q;
    v1_d = v1_q;
    v2_d = v2_q;
    e_d = e_q;
    il_d = il_q;
    ic_d = ic_q;
    z0_d = z0_q;
    z1_d = z1_q;
    z2_d = z2_q;
    sat_d = sat_q;
    case (state_q)
      IDLE: begin
        if (hist_clr) begin
          il_d = '0;
          ic_d = '0;
          sat_d = 1'b0;
        end
        if (in_valid) begin
          state_d = MUL_L;
          v1_d = v1;
          v2_d = v2;
          e_d = e_src;
        end
      end
      MUL_L: begin
        il_d = sl[W-1:0];
        sat_d = sat_q | sl[W];
        state_d = MUL_C;
      end
      MUL_C: begin
        ic_d = sc[W-1:0];
        z0_d = s0[W-1:0];
        z1_d = s1[W-1:0];
        z2_d = e_q;
        sat_d = sat_q | sc[W] | s0[W] | s1[W];
        state_d = OUT;
      end
      default: state_d = out_ready ? IDLE : OUT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v1_q <= '0;
      v2_q <= '0;
      e_q <= '0;
      il_q <= '0;
      ic_q <= '0;
      z0_q <= '0;
      z1_q <= '0;
      z2_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      e_q <= e_d;
      il_q <= il_d;
      ic_q <= ic_d;
      z0_q <= z0_d;
      z1_q <= z1_d;
      z2_q <= z2_d;
      sat_q <= sat_d;
    end
  end

  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == OUT;
  assign z0 = z0_q;
  assign z1 = z1_q;
  assign z2 = z2_q;
  assign sat = sat_q;
endmodule

// File: tb/tb_companion_state_update.sv
// tb_companion_state_update: directed vector table plus back-pressure and async-reset sequences
module tb_companion_state_update;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, hist_clr = 1'b0, out_ready = 1'b0;
  logic signed [15:0] v1 = '0, v2 = '0, e_src = '0;
  logic in_ready, out_valid, sat;
  logic [15:0] z0, z1, z2;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic clr;
    logic [15:0] v1, v2, e, z0, z1, z2;
    logic sat;
  } vec_t;
  vec_t vecs[8];

  companion_state_update dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .v1(v1), .v2(v2), .e_src(e_src), .hist_clr(hist_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .z0(z0), .z1(z1), .z2(z2), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge where out_valid is expected.
  task automatic start_step(input logic clr, input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
    int n;
    hist_clr = clr;
    v1 = a;
    v2 = b;
    e_src = e;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    hist_clr = 1'b0;
    check("early_out_valid", 16'(out_valid), 16'h0);
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency", 16'(n), 16'd3);
  endtask

  task automatic expect_z(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic es);
    check({tag, "_z0"}, z0, e0);
    check({tag, "_z1"}, z1, e1);
    check({tag, "_z2"}, z2, e2);
    check({tag, "_sat"}, 16'(sat), 16'(es));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("back_to_idle", 16'(in_ready), 16'h1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h0200, 16'h0100, 16'h0300, 16'hFF80, 16'h0280, 16'h0300, 1'b0};
    vecs[1] = '{1'b0, 16'h0200, 16'h0100, 16'h0300, 16'hFF00, 16'h0100, 16'h0300, 1'b0};
    vecs[2] = '{1'b1, 16'h7FFF, 16'h8000, 16'h0011, 16'h8001, 16'hFFFF, 16'h0011, 1'b1};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h8000, 16'h0022, 16'h8001, 16'hFFFF, 16'h0022, 1'b1};
    vecs[4] = '{1'b1, 16'h8000, 16'h7FFF, 16'h0033, 16'h7FFF, 16'hFFFF, 16'h0033, 1'b1};
    vecs[5] = '{1'b1, 16'h0200, 16'h0100, 16'h0300, 16'hFF80, 16'h0280, 16'h0300, 1'b0};
    vecs[6] = '{1'b0, 16'hFF00, 16'h0100, 16'h1234, 16'h0080, 16'hFF80, 16'h1234, 1'b0};
    vecs[7] = '{1'b1, 16'h0000, 16'h0001, 16'hABCD, 16'h0001, 16'h0001, 16'hABCD, 1'b0};

    #1;
    expect_z("reset", 16'h0, 16'h0, 16'h0, 1'b0);
    check("reset_in_ready", 16'(in_ready), 16'h1);
    check("reset_out_valid", 16'(out_valid), 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      start_step(vecs[i].clr, vecs[i].v1, vecs[i].v2, vecs[i].e);
      expect_z($sformatf("vec%0d", i), vecs[i].z0, vecs[i].z1, vecs[i].z2, vecs[i].sat);
      handshake();
    end

    start_step(1'b1, 16'h0200, 16'h0100, 16'h0300);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2) == 0;
      v1 = 16'h7777;
      v2 = 16'h1111;
      @(negedge clk);
      expect_z($sformatf("hold%0d", i), 16'hFF80, 16'h0280, 16'h0300, 1'b0);
      check("hold_out_valid", 16'(out_valid), 16'h1);
      check("hold_in_ready", 16'(in_ready), 16'h0);
    end
    in_valid = 1'b0;
    handshake();
    start_step(1'b0, 16'h0200, 16'h0100, 16'h0300);
    expect_z("after_hold", 16'hFF00, 16'h0100, 16'h0300, 1'b0);
    handshake();

    hist_clr = 1'b1;
    v1 = 16'h7FFF;
    v2 = 16'h8000;
    e_src = 16'h0055;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    hist_clr = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_z("async_rst", 16'h0, 16'h0, 16'h0, 1'b0);
    check("async_in_ready", 16'(in_ready), 16'h1);
    check("async_out_valid", 16'(out_valid), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_step(1'b0, 16'h0200, 16'h0100, 16'h0300);
    expect_z("post_rst", 16'hFF80, 16'h0280, 16'h0300, 1'b0);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
